wrr_sched: RTL and testbench



---
 rtl/wrr_sched_if.sv | 26 ++
 rtl/wrr_sched.sv | 131 +++++++++++++
 tb/tb_wrr_sched.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/wrr_sched_if.sv
// Request/config/grant bundle for the weighted round-robin packet scheduler.
// The master drives requests and configuration; the slave (scheduler) returns the grant.
interface wrr_sched_if #(
   parameter int NUM_QUEUES   = 8,
   parameter int WEIGHT_WIDTH = 4
);
   logic [NUM_QUEUES-1:0]   req;
   logic                    pkt_done;
   logic                    cfg_wr;
   logic [2:0]              cfg_addr;
   logic [WEIGHT_WIDTH-1:0] cfg_wdata;
   logic [NUM_QUEUES-1:0]   grant;
   logic [2:0]              grant_idx;
   logic                    grant_valid;
   logic [15:0]             round_cnt;

   modport master (
      output req, pkt_done, cfg_wr, cfg_addr, cfg_wdata,
      input  grant, grant_idx, grant_valid, round_cnt
   );

   modport slave (
      input  req, pkt_done, cfg_wr, cfg_addr, cfg_wdata,
      output grant, grant_idx, grant_valid, round_cnt
   );
endinterface

// File: rtl/wrr_sched.sv
// Weighted round-robin packet scheduler: each queue gets up to weight[i] packets
// per round; credits are refilled from the weights once no eligible queue remains.
module wrr_sched #(
   parameter int NUM_QUEUES   = 8,
   parameter int WEIGHT_WIDTH = 4,
   parameter int RESET_WEIGHT = 1
) (
   input logic       clk,
   input logic       reset,
   wrr_sched_if.slave bus
);
   localparam int IW = $clog2(NUM_QUEUES);

   typedef enum logic [1:0] {SCAN, GRANT, RELOAD} state_t;

   state_t                  state_q, state_d;
   logic [IW-1:0]           ptr_q, ptr_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic                    gv_q, gv_d;
   logic [NUM_QUEUES-1:0]   grant_q, grant_d;
   logic [15:0]             round_q, round_d;
   logic [WEIGHT_WIDTH-1:0] weight_q [NUM_QUEUES];
   logic [WEIGHT_WIDTH-1:0] credit_q [NUM_QUEUES];
   logic [WEIGHT_WIDTH-1:0] credit_d [NUM_QUEUES];
   logic [WEIGHT_WIDTH-1:0] newc;

   logic [NUM_QUEUES-1:0]   elig;
   logic [NUM_QUEUES-1:0]   active;
   logic                    found;
   logic [IW-1:0]           pick;
   logic [IW-1:0]           cand;

   function automatic logic [WEIGHT_WIDTH-1:0] dec_sat(input logic [WEIGHT_WIDTH-1:0] v);
      return (v == '0) ? '0 : v - WEIGHT_WIDTH'(1);
   endfunction

   function automatic logic [NUM_QUEUES-1:0] onehot(input logic [IW-1:0] i);
      logic [NUM_QUEUES-1:0] r;
      r    = '0;
      r[i] = 1'b1;
      return r;
   endfunction

   always_comb begin
      for (int i = 0; i < NUM_QUEUES; i++) begin
         elig[i]   = bus.req[i] && (credit_q[i] != '0);
         active[i] = bus.req[i] && (weight_q[i] != '0);
      end
   end

   // First eligible queue at or after ptr, wrapping modulo NUM_QUEUES.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int k = 0; k < NUM_QUEUES; k++) begin
         cand = ptr_q + IW'(k);
         if (!found && elig[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      idx_d    = idx_q;
      gv_d     = gv_q;
      round_d  = round_q;
      credit_d = credit_q;
      newc     = '0;
      case (state_q)
         SCAN: begin
            if (found) begin
               gv_d    = 1'b1;
               idx_d   = pick;
               state_d = GRANT;
            end else if (|active) begin
               state_d = RELOAD;
            end
         end
         GRANT: begin
            if (bus.pkt_done) begin
               newc            = dec_sat(credit_q[idx_q]);
               credit_d[idx_q] = newc;
               gv_d            = 1'b0;
               state_d         = SCAN;
               ptr_d           = (newc != '0) ? idx_q : idx_q + IW'(1);
            end
         end
         RELOAD: begin
            for (int i = 0; i < NUM_QUEUES; i++) credit_d[i] = weight_q[i];
            round_d = round_q + 16'd1;
            state_d = SCAN;
         end
         default: state_d = SCAN;
      endcase
      grant_d = gv_d ? onehot(idx_d) : '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= SCAN;
         ptr_q   <= '0;
         idx_q   <= '0;
         gv_q    <= 1'b0;
         grant_q <= '0;
         round_q <= '0;
         for (int i = 0; i < NUM_QUEUES; i++) begin
            credit_q[i] <= '0;
            weight_q[i] <= WEIGHT_WIDTH'(RESET_WEIGHT);
         end
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         idx_q    <= idx_d;
         gv_q     <= gv_d;
         grant_q  <= grant_d;
         round_q  <= round_d;
         credit_q <= credit_d;
         // A reload in the same cycle samples weight_q before this write lands.
         if (bus.cfg_wr) weight_q[bus.cfg_addr] <= bus.cfg_wdata;
      end
   end

   assign bus.grant       = grant_q;
   assign bus.grant_idx   = idx_q;
   assign bus.grant_valid = gv_q;
   assign bus.round_cnt   = round_q;
endmodule

// File: tb/tb_wrr_sched.sv
// Directed bench for wrr_sched: a vector table for single-cycle behaviour plus
// hand-written sequences for round ordering, config/reload overlap and reset.
module tb_wrr_sched;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   wrr_sched_if bus ();
   wrr_sched dut (.clk(clk), .reset(reset), .bus(bus));

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [7:0]  req;
      logic        done;
      logic        wr;
      logic [2:0]  addr;
      logic [3:0]  wdata;
      logic        gv;
      logic [2:0]  idx;
      logic [7:0]  gnt;
      logic [15:0] rnd;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic [7:0] req, input logic done, input logic wr,
                      input logic [2:0] addr, input logic [3:0] wdata, input logic gv,
                      input logic [2:0] idx, input logic [7:0] gnt, input logic [15:0] rnd);
      vec_t v;
      v = '{req, done, wr, addr, wdata, gv, idx, gnt, rnd};
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.req       = '0;
      bus.pkt_done  = 1'b0;
      bus.cfg_wr    = 1'b0;
      bus.cfg_addr  = '0;
      bus.cfg_wdata = '0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      idle();
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic cfg(input logic [2:0] addr, input logic [3:0] data);
      bus.cfg_wr    = 1'b1;
      bus.cfg_addr  = addr;
      bus.cfg_wdata = data;
      tick();
      bus.cfg_wr    = 1'b0;
   endtask

   task automatic wait_gv(input string name);
      int n = 0;
      while (bus.grant_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      total++;
      if (bus.grant_valid !== 1'b1) begin
         bad++;
         $display("FAIL %s: grant_valid=%0b after %0d cycles, required 1", name, bus.grant_valid, n);
      end
   endtask

   task automatic pulse_done();
      bus.pkt_done = 1'b1;
      tick();
      bus.pkt_done = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      // Table: starts from reset, all weights 1.
      add(8'h01,0,0,0,0, 0,0,8'h00,16'd0);
      add(8'h01,0,0,0,0, 0,0,8'h00,16'd1);
      add(8'h01,0,0,0,0, 1,0,8'h01,16'd1);
      add(8'h00,0,0,0,0, 1,0,8'h01,16'd1);
      add(8'h00,1,0,0,0, 0,0,8'h00,16'd1);
      add(8'h00,0,0,0,0, 0,0,8'h00,16'd1);
      add(8'h00,0,1,2,0, 0,0,8'h00,16'd1);
      add(8'h04,0,0,0,0, 1,2,8'h04,16'd1);
      add(8'h04,1,0,0,0, 0,0,8'h00,16'd1);
      add(8'h04,0,0,0,0, 0,0,8'h00,16'd1);
      add(8'h04,0,0,0,0, 0,0,8'h00,16'd1);
      add(8'h04,0,0,0,0, 0,0,8'h00,16'd1);
      add(8'h04,1,0,0,0, 0,0,8'h00,16'd1);
      add(8'h06,0,0,0,0, 1,1,8'h02,16'd1);
      add(8'h00,0,0,0,0, 1,1,8'h02,16'd1);
      add(8'h06,1,0,0,0, 0,0,8'h00,16'd1);
      add(8'h06,0,0,0,0, 0,0,8'h00,16'd1);
      add(8'h06,0,0,0,0, 0,0,8'h00,16'd2);
      add(8'h06,0,0,0,0, 1,1,8'h02,16'd2);
      add(8'h06,1,0,0,0, 0,0,8'h00,16'd2);

      do_reset();
      chk("rst_gv", bus.grant_valid, 0);
      chk("rst_idx", bus.grant_idx, 0);
      chk("rst_grant", bus.grant, 0);
      chk("rst_round", bus.round_cnt, 0);
      for (int i = 0; i < 8; i++) begin
         chk("rst_credit", dut.credit_q[i], 0);
         chk("rst_weight", dut.weight_q[i], 1);
      end

      foreach (tbl[i]) begin
         bus.req       = tbl[i].req;
         bus.pkt_done  = tbl[i].done;
         bus.cfg_wr    = tbl[i].wr;
         bus.cfg_addr  = tbl[i].addr;
         bus.cfg_wdata = tbl[i].wdata;
         tick();
         chk($sformatf("vec%0d_gv", i), bus.grant_valid, tbl[i].gv);
         chk($sformatf("vec%0d_grant", i), bus.grant, tbl[i].gnt);
         chk($sformatf("vec%0d_round", i), bus.round_cnt, tbl[i].rnd);
         if (tbl[i].gv) chk($sformatf("vec%0d_idx", i), bus.grant_idx, tbl[i].idx);
      end
      idle();

      // Two full rounds with weights {1,1,1,7,7,7,7,7}, all queues requesting.
      do_reset();
      for (int q = 3; q < 8; q++) cfg(3'(q), 4'd7);
      bus.req = 8'hFF;
      for (int r = 0; r < 2; r++) begin
         for (int q = 0; q < 8; q++) begin
            for (int k = 0; k < ((q < 3) ? 1 : 7); k++) begin
               wait_gv("order_wait");
               chk($sformatf("order_r%0d_q%0d_idx", r, q), bus.grant_idx, q);
               chk($sformatf("order_r%0d_q%0d_grant", r, q), bus.grant, 32'(1) << q);
               chk($sformatf("order_r%0d_q%0d_round", r, q), bus.round_cnt, r + 1);
               tick();
               tick();
               pulse_done();
               chk("order_drop", bus.grant_valid, 0);
            end
         end
      end
      idle();

      // Zero weight on the only requester: no reload, no grant.
      do_reset();
      cfg(3'd2, 4'd0);
      bus.req = 8'h04;
      repeat (6) tick();
      chk("zero_w_gv", bus.grant_valid, 0);
      chk("zero_w_round", bus.round_cnt, 0);
      idle();

      // Grant held against req changes; second pkt_done outside GRANT ignored.
      do_reset();
      cfg(3'd3, 4'd3);
      bus.req = 8'h08;
      wait_gv("hold_wait");
      chk("hold_idx", bus.grant_idx, 3);
      chk("hold_credit_pre", dut.credit_q[3], 3);
      bus.req = 8'h00;
      tick();
      chk("hold_gv", bus.grant_valid, 1);
      chk("hold_idx2", bus.grant_idx, 3);
      chk("hold_grant", bus.grant, 8'h08);
      pulse_done();
      chk("hold_drop", bus.grant_valid, 0);
      chk("hold_credit_dec", dut.credit_q[3], 2);
      tick();
      pulse_done();
      chk("hold_ignored_gv", bus.grant_valid, 0);
      chk("hold_ignored_credit", dut.credit_q[3], 2);
      idle();

      // Weight write landing in the RELOAD cycle.
      do_reset();
      bus.req = 8'h20;
      tick();
      chk("cfgrl_round0", bus.round_cnt, 0);
      bus.cfg_wr    = 1'b1;
      bus.cfg_addr  = 3'd5;
      bus.cfg_wdata = 4'd2;
      tick();
      bus.cfg_wr = 1'b0;
      chk("cfgrl_old_credit", dut.credit_q[5], 1);
      chk("cfgrl_round1", bus.round_cnt, 1);
      chk("cfgrl_weight", dut.weight_q[5], 2);
      wait_gv("cfgrl_wait");
      chk("cfgrl_idx", bus.grant_idx, 5);
      pulse_done();
      chk("cfgrl_credit0", dut.credit_q[5], 0);
      tick();
      tick();
      chk("cfgrl_new_credit", dut.credit_q[5], 2);
      chk("cfgrl_round2", bus.round_cnt, 2);

      // Asynchronous reset in the middle of a grant.
      wait_gv("arst_wait");
      chk("arst_pre_gv", bus.grant_valid, 1);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_gv", bus.grant_valid, 0);
      chk("arst_grant", bus.grant, 0);
      chk("arst_round", bus.round_cnt, 0);
      for (int i = 0; i < 8; i++) chk("arst_credit", dut.credit_q[i], 0);
      chk("arst_weight", dut.weight_q[5], 1);
      @(negedge clk);
      idle();
      reset = 1'b1;
      tick();
      chk("arst_after_gv", bus.grant_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
